// File: rtl/seq_accumulator_pkg.sv
// Shared types and sizing helpers for the sequential accumulator.
package seq_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Wide enough to hold NUM_OPS full-scale unsigned operands without overflow.
   function automatic int default_sum_width(input int width, input int num_ops);
      return width + $clog2(num_ops);
   endfunction

   function automatic int step_width(input int num_ops);
      return (num_ops < 2) ? 1 : $clog2(num_ops);
   endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Single-cycle rising-edge detector. The history register resets high so a
// level already asserted when reset releases is not reported as an edge.
module rising_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic rise
);

   logic in_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         in_reg <= 1'b1;
      end else begin
         in_reg <= in;
      end
   end

   assign rise = in & ~in_reg;

endmodule

// File: rtl/seq_accumulator.sv
// Multi-cycle accumulator: a trigger edge folds NUM_OPS operands into sum, one per clock.
// Define SEQ_ACCUMULATOR_SATURATE_EN to clamp every step to 0..2^SUM_WIDTH-1.
module seq_accumulator
   import seq_accumulator_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int NUM_OPS   = 3,
   parameter int SUM_WIDTH = default_sum_width(WIDTH, NUM_OPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trigger,
   input  logic [NUM_OPS*WIDTH-1:0] operands,
   input  logic [NUM_OPS-1:0]       sub_mask,
   output logic [SUM_WIDTH-1:0]     sum,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun
);

   localparam int STEP_W = step_width(NUM_OPS);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_OPS - 1);

   state_t               state_reg, state_next;
   logic [STEP_W-1:0]    step_reg, step_next;
   logic [SUM_WIDTH-1:0] sum_reg, sum_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic                 overrun_reg, overrun_next;

   logic                 rise;
   logic [SUM_WIDTH-1:0] op_ext [NUM_OPS];
   logic [SUM_WIDTH-1:0] cur_op;
   logic                 cur_sub;
   logic [SUM_WIDTH-1:0] step_result;

   rising_edge_detect u_edge (
      .clk   (clk),
      .reset (reset),
      .in    (trigger),
      .rise  (rise)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OPS; gi++) begin : g_unpack
         assign op_ext[gi] = SUM_WIDTH'(operands[gi*WIDTH +: WIDTH]);
      end
   endgenerate

   assign cur_op  = op_ext[step_reg];
   assign cur_sub = sub_mask[step_reg];

`ifdef SEQ_ACCUMULATOR_SATURATE_EN
   logic [SUM_WIDTH:0] add_full;
   logic [SUM_WIDTH:0] sub_full;

   assign add_full = {1'b0, sum_reg} + {1'b0, cur_op};
   assign sub_full = {1'b0, sum_reg} - {1'b0, cur_op};

   // The extra MSB is the carry on add and the borrow on subtract.
   always_comb begin
      step_result = add_full[SUM_WIDTH-1:0];
      if (cur_sub) begin
         step_result = sub_full[SUM_WIDTH] ? '0 : sub_full[SUM_WIDTH-1:0];
      end else if (add_full[SUM_WIDTH]) begin
         step_result = '1;
      end
   end
`else
   assign step_result = cur_sub ? (sum_reg - cur_op) : (sum_reg + cur_op);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         step_reg    <= '0;
         sum_reg     <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         step_reg    <= step_next;
         sum_reg     <= sum_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         overrun_reg <= overrun_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      step_next    = step_reg;
      sum_next     = sum_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      overrun_next = 1'b0;

      case (state_reg)
         IDLE, FINISH: begin
            state_next = IDLE;
            // FINISH is not busy, so an edge there starts the next sequence.
            if (rise) begin
               sum_next   = op_ext[0];
               step_next  = STEP_W'(1);
               busy_next  = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            sum_next     = step_result;
            step_next    = step_reg + 1'b1;
            overrun_next = rise;
            if (step_reg == LAST_STEP) begin
               step_next  = '0;
               busy_next  = 1'b0;
               done_next  = 1'b1;
               state_next = FINISH;
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   assign sum     = sum_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;
   assign overrun = overrun_reg;

endmodule

// File: tb/tb_seq_accumulator.sv
// Self-checking bench for seq_accumulator (default 3x16-bit build plus a 2-operand,
// 16-bit-sum instance) against an integer reference fold.
module tb_seq_accumulator;

   localparam int W     = 16;
   localparam int NOPS  = 3;
   localparam int SW    = 18;
   localparam int NOPS2 = 2;
   localparam int SW2   = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 trigger;
   logic [NOPS*W-1:0]    operands;
   logic [NOPS-1:0]      sub_mask;
   logic [SW-1:0]        sum;
   logic                 busy, done, overrun;

   logic [NOPS2*W-1:0]   operands2;
   logic [NOPS2-1:0]     sub_mask2;
   logic [SW2-1:0]       sum2;
   logic                 busy2, done2, overrun2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_accumulator #(.WIDTH(W), .NUM_OPS(NOPS)) dut (
      .clk      (clk),
      .reset    (reset),
      .trigger  (trigger),
      .operands (operands),
      .sub_mask (sub_mask),
      .sum      (sum),
      .busy     (busy),
      .done     (done),
      .overrun  (overrun)
   );

   seq_accumulator #(.WIDTH(W), .NUM_OPS(NOPS2), .SUM_WIDTH(SW2)) dut2 (
      .clk      (clk),
      .reset    (reset),
      .trigger  (trigger),
      .operands (operands2),
      .sub_mask (sub_mask2),
      .sum      (sum2),
      .busy     (busy2),
      .done     (done2),
      .overrun  (overrun2)
   );

   // Reference: signed integer fold of the first n operands, then wrap or clamp each step.
   function automatic longint model_fold(input logic [NOPS*W-1:0] ops,
                                         input logic [NOPS-1:0] mask,
                                         input int n, input int sw);
      longint acc;
      longint maxv;
      longint v;
      acc  = 0;
      maxv = (longint'(1) << sw) - 1;
      for (int i = 0; i < n; i++) begin
         v = longint'(ops[i*W +: W]);
         if (i > 0 && mask[i]) acc = acc - v;
         else                  acc = acc + v;
`ifdef SEQ_ACCUMULATOR_SATURATE_EN
         if (acc < 0)    acc = 0;
         if (acc > maxv) acc = maxv;
`else
         acc = acc & maxv;
`endif
      end
      return acc;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      trigger = 1'b0;
      operands = '0;
      sub_mask = '0;
      operands2 = '0;
      sub_mask2 = '0;
      tick();
      tick();
      checks++; if (sum !== '0)      begin errors++; $display("FAIL reset_sum got=%0h want=0", sum); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
      checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", overrun); end
      reset = 1'b0;
      tick();
      $display("reset: sum=%0h busy=%b done=%b overrun=%b", sum, busy, done, overrun);
   endtask

   // One full sequence from IDLE; per-cycle sum/busy/done checked against the model.
   task automatic run_seq(input logic [NOPS*W-1:0] ops, input logic [NOPS-1:0] mask,
                          input longint exp_final, input string name);
      longint want;
      trigger = 1'b0;
      tick();
      operands = ops;
      sub_mask = mask;
      trigger  = 1'b1;
      for (int k = 1; k <= NOPS; k++) begin
         tick();
         trigger = 1'b0;
         want = model_fold(ops, mask, k, SW);
         checks++; if (longint'(sum) != want) begin errors++; $display("FAIL %s_sum_step%0d got=%0h want=%0h", name, k, sum, want); end
         checks++; if (busy !== (k < NOPS)) begin errors++; $display("FAIL %s_busy_step%0d got=%b want=%b", name, k, busy, (k < NOPS)); end
         checks++; if (done !== (k == NOPS)) begin errors++; $display("FAIL %s_done_step%0d got=%b want=%b", name, k, done, (k == NOPS)); end
         checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL %s_overrun_step%0d got=%b want=0", name, k, overrun); end
      end
      if (exp_final >= 0) begin
         checks++; if (longint'(sum) != exp_final) begin errors++; $display("FAIL %s_final got=%0h want=%0h", name, sum, exp_final); end
      end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_drop got=%b want=0", name, done); end
      checks++; if (longint'(sum) != want) begin errors++; $display("FAIL %s_hold got=%0h want=%0h", name, sum, want); end
      $display("seq %s: ops=%h mask=%b sum=%0h model=%0h", name, ops, mask, sum, want);
   endtask

   task automatic test_directed();
      longint wrap_exp;
`ifdef SEQ_ACCUMULATOR_SATURATE_EN
      wrap_exp = 2;
`else
      wrap_exp = 1;
`endif
      run_seq({16'd10, 16'd7, 16'd5}, 3'b000, 22, "add3");
      run_seq({16'd20, 16'd30, 16'd100}, 3'b110, 50, "sub2");
      run_seq({16'd2, 16'd1, 16'd0}, 3'b010, wrap_exp, "underflow");
      run_seq({16'hFFFF, 16'hFFFF, 16'hFFFF}, 3'b000, 64'h2FFFD, "fullscale");
   endtask

   task automatic test_random();
      logic [NOPS*W-1:0] ops;
      logic [NOPS-1:0]   mask;
      for (int r = 0; r < 16; r++) begin
         ops  = {16'($urandom), 16'($urandom), 16'($urandom)};
         mask = 3'($urandom);
         run_seq(ops, mask, -1, "random");
      end
   endtask

   task automatic test_overrun();
      int ov_cnt = 0;
      int done_cnt = 0;
      trigger = 1'b0;
      tick();
      operands = {16'd10, 16'd7, 16'd5};
      sub_mask = 3'b000;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      trigger = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (overrun === 1'b1) ov_cnt++;
         if (done === 1'b1) done_cnt++;
      end
      trigger = 1'b0;
      checks++; if (ov_cnt != 1)   begin errors++; $display("FAIL overrun_pulses got=%0d want=1", ov_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL overrun_done_count got=%0d want=1", done_cnt); end
      checks++; if (sum !== 18'd22) begin errors++; $display("FAIL overrun_sum got=%0d want=22", sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL overrun_busy got=%b want=0", busy); end
      $display("overrun: pulses=%0d dones=%0d sum=%0d", ov_cnt, done_cnt, sum);
      tick();
   endtask

   task automatic test_back_to_back();
      trigger = 1'b0;
      tick();
      operands = {16'd10, 16'd7, 16'd5};
      sub_mask = 3'b000;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b want=1", done); end
      // Rising edge during the FINISH cycle with a fresh operand set.
      operands = {16'd20, 16'd30, 16'd100};
      sub_mask = 3'b110;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got=%b want=1", busy); end
      checks++; if (sum !== 18'd100) begin errors++; $display("FAIL b2b_restart_sum got=%0d want=100", sum); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
      tick();
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b want=1", done); end
      checks++; if (sum !== 18'd50) begin errors++; $display("FAIL b2b_second_sum got=%0d want=50", sum); end
      $display("back_to_back: second sum=%0d done=%b", sum, done);
      tick();
   endtask

   task automatic test_reset_mid();
      int done_cnt = 0;
      int busy_cnt = 0;
      trigger = 1'b0;
      tick();
      operands = {16'd10, 16'd7, 16'd5};
      sub_mask = 3'b000;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      reset = 1'b1;
      tick();
      checks++; if (sum !== '0)    begin errors++; $display("FAIL midreset_sum got=%0h want=0", sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", busy); end
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (done === 1'b1) done_cnt++;
         if (busy === 1'b1) busy_cnt++;
      end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_done got=%0d want=0", done_cnt); end
      checks++; if (busy_cnt != 0) begin errors++; $display("FAIL midreset_restart got=%0d want=0", busy_cnt); end
      $display("reset_mid: sum=%0h dones=%0d", sum, done_cnt);
   endtask

   task automatic test_trigger_held();
      int busy_cnt = 0;
      trigger = 1'b1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (busy === 1'b1) busy_cnt++;
      end
      checks++; if (busy_cnt != 0) begin errors++; $display("FAIL held_no_start got=%0d want=0", busy_cnt); end
      trigger = 1'b0;
      tick();
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_restart_busy got=%b want=1", busy); end
      checks++; if (sum !== 18'd5) begin errors++; $display("FAIL held_restart_sum got=%0d want=5", sum); end
      $display("trigger_held: busy_cycles_while_held=%0d restart_sum=%0d", busy_cnt, sum);
      for (int c = 0; c < 4; c++) tick();
   endtask

   task automatic test_narrow();
      longint want;
      longint exp_const;
`ifdef SEQ_ACCUMULATOR_SATURATE_EN
      exp_const = 64'hFFFF;
`else
      exp_const = 64'hFFFE;
`endif
      trigger = 1'b0;
      tick();
      operands2 = {16'hFFFF, 16'hFFFF};
      sub_mask2 = 2'b00;
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      tick();
      want = model_fold({16'h0, operands2}, {1'b0, sub_mask2}, NOPS2, SW2);
      checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL narrow_done got=%b want=1", done2); end
      checks++; if (longint'(sum2) != want) begin errors++; $display("FAIL narrow_model got=%0h want=%0h", sum2, want); end
      checks++; if (longint'(sum2) != exp_const) begin errors++; $display("FAIL narrow_const got=%0h want=%0h", sum2, exp_const); end
      $display("narrow: sum2=%0h model=%0h", sum2, want);
      for (int c = 0; c < 3; c++) tick();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_trigger_held();
      test_narrow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
